// File: rtl/radix4_booth_param.sv
// Radix-4 Booth multiplier with a parameterised operand width.
// It retires one recoded digit per clock. The operand mode (signed or
// unsigned) is selected per operation. The product register only updates
// when an operation completes.
module radix4_booth_param #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [W-1:0]   mplier,
    input  logic [W-1:0]   mpcand,
    input  logic           go,
    input  logic           sgn,
    output logic [2*W-1:0] pdt,
    output logic           over,
    output logic           busy
);

    // state | meaning
    // IDLE  | waiting for go; operands are latched on the accepting edge
    // RUN   | one Booth digit retired per cycle
    // DONE  | product valid, over pulse high; returns to IDLE next edge

    // The accumulator carries two guard bits above the 2W product. This keeps
    // every unsigned partial sum in range before it is truncated.
    localparam int AW = 2 * W + 2;
    // The multiplier shifter holds the 2-bit extension, the operand and the
    // implicit m[-1] guard bit at the bottom.
    localparam int MW = W + 3;
    localparam int CW = $clog2(W / 2 + 2);
    localparam logic [CW-1:0] LAST_SGN = CW'(W / 2 - 1);
    localparam logic [CW-1:0] LAST_UNS = CW'(W / 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [MW-1:0]    m_q;
    logic [MW-1:0]    m_d;
    logic [AW-1:0]    mc_q;
    logic [AW-1:0]    mc_d;
    logic [AW-1:0]    acc_q;
    logic [AW-1:0]    acc_d;
    logic [CW-1:0]    cnt_q;
    logic             sgn_q;
    logic [2*W-1:0]   pdt_q;
    logic             over_q;
    logic             busy_q;

    logic [MW-1:0]    m_ext;
    logic [AW-1:0]    mc_ext;
    logic [2:0]       window;
    logic [AW-1:0]    mc_x2;
    logic [AW-1:0]    pp;
    logic             last_digit;

    // Extend both operands according to the requested mode before they are latched.
    always_comb begin
        m_ext  = {{2{sgn & mplier[W-1]}}, mplier, 1'b0};
        mc_ext = {{(AW - W){sgn & mpcand[W-1]}}, mpcand};
    end

    // Recode the low window of the shifting multiplier into a partial product.
    // The multiplicand register is already aligned to weight 2i.
    always_comb begin
        window = m_q[2:0];
        mc_x2  = {mc_q[AW-2:0], 1'b0};
        pp     = '0;
        unique case (window)
            3'b001, 3'b010: pp = mc_q;
            3'b011:         pp = mc_x2;
            3'b100:         pp = ~mc_x2 + AW'(1);
            3'b101, 3'b110: pp = ~mc_q + AW'(1);
            default:        pp = '0;
        endcase
    end

    // Advance the datapath by one digit: accumulate, then realign both shifters.
    always_comb begin
        acc_d      = acc_q + pp;
        m_d        = {m_q[MW-1], m_q[MW-1], m_q[MW-1:2]};
        mc_d       = {mc_q[AW-3:0], 2'b00};
        last_digit = (cnt_q == (sgn_q ? LAST_SGN : LAST_UNS));
    end

    // Sequence the operation. The outputs are registered so that pdt never exposes a partial sum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            m_q     <= '0;
            mc_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            pdt_q   <= '0;
            over_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    over_q <= 1'b0;
                    if (go) begin
                        m_q     <= m_ext;
                        mc_q    <= mc_ext;
                        sgn_q   <= sgn;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    m_q   <= m_d;
                    mc_q  <= mc_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_digit) begin
                        pdt_q   <= acc_d[2*W-1:0];
                        over_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    over_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    over_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pdt  = pdt_q;
    assign over = over_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_radix4_booth_param.sv
// Directed test bench for radix4_booth_param. It runs an 8-bit and a 16-bit
// instance against products that were computed by hand.
module tb_radix4_booth_param;

    logic        clk = 1'b0;
    logic        reset;

    logic [7:0]  mplier8, mpcand8;
    logic        go8, sgn8;
    logic [15:0] pdt8;
    logic        over8, busy8;

    logic [15:0] mplier16, mpcand16;
    logic        go16, sgn16;
    logic [31:0] pdt16;
    logic        over16, busy16;

    int n_checks = 0;
    int n_errors = 0;

    radix4_booth_param #(.W(8)) dut8 (
        .clk    (clk),
        .reset  (reset),
        .mplier (mplier8),
        .mpcand (mpcand8),
        .go     (go8),
        .sgn    (sgn8),
        .pdt    (pdt8),
        .over   (over8),
        .busy   (busy8)
    );

    radix4_booth_param #(.W(16)) dut16 (
        .clk    (clk),
        .reset  (reset),
        .mplier (mplier16),
        .mpcand (mpcand16),
        .go     (go16),
        .sgn    (sgn16),
        .pdt    (pdt16),
        .over   (over16),
        .busy   (busy16)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Start one 8-bit operation, scramble the inputs while it runs, then check
    // the latency, the product and that over is a single-cycle pulse.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic s, input logic [15:0] exp_p, input int exp_lat);
        int lat;
        lat = 0;
        @(negedge clk);
        mplier8 = a; mpcand8 = b; sgn8 = s; go8 = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_busy"}, 64'(busy8), 64'd1);
        @(negedge clk);
        go8 = 1'b0; mplier8 = ~a; mpcand8 = ~b; sgn8 = ~s;
        for (int n = 1; n <= 12 && lat == 0; n++) begin
            @(posedge clk); #1;
            if (over8) lat = n;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_pdt"}, 64'(pdt8), 64'(exp_p));
        @(posedge clk); #1;
        chk({tag, "_over1"}, 64'(over8), 64'd0);
        chk({tag, "_idle"}, 64'(busy8), 64'd0);
    endtask

    initial begin
        int overs;
        int first_lat;
        int second_lat;
        logic [15:0] pdt_at_over;

        reset = 1'b1;
        go8 = 1'b0; sgn8 = 1'b0; mplier8 = '0; mpcand8 = '0;
        go16 = 1'b0; sgn16 = 1'b0; mplier16 = '0; mpcand16 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pdt", 64'(pdt8), 64'd0);
        chk("rst_over", 64'(over8), 64'd0);
        chk("rst_busy", 64'(busy8), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Signed products; the expected results are the 16-bit two's complement values.
        run_op("s13x27",   8'h0D, 8'h1B, 1'b1, 16'h015F, 4);
        run_op("s25xm7",   8'h19, 8'hF9, 1'b1, 16'hFF51, 4);
        run_op("sm18x17",  8'hEE, 8'h11, 1'b1, 16'hFECE, 4);
        run_op("sm19xm33", 8'hED, 8'hDF, 1'b1, 16'h0273, 4);
        run_op("smaxneg",  8'h80, 8'h80, 1'b1, 16'h4000, 4);
        run_op("s0x5",     8'h00, 8'h05, 1'b1, 16'h0000, 4);
        // Unsigned products take one extra digit.
        run_op("u255x255", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 5);
        run_op("u200x3",   8'hC8, 8'h03, 1'b0, 16'h0258, 5);

        // Change the operands and pulse go while the operation is running.
        overs = 0;
        pdt_at_over = '0;
        @(negedge clk);
        mplier8 = 8'h0D; mpcand8 = 8'h1B; sgn8 = 1'b1; go8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        go8 = 1'b0; mplier8 = 8'h05; mpcand8 = 8'h06;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (over8) begin
                overs++;
                pdt_at_over = pdt8;
            end
            @(negedge clk);
            go8 = (n == 2);
        end
        go8 = 1'b0;
        chk("midrun_overs", 64'(overs), 64'd1);
        chk("midrun_pdt", 64'(pdt_at_over), 64'h015F);
        run_op("next5x6", 8'h05, 8'h06, 1'b1, 16'h001E, 4);

        // Assert reset in the middle of an operation.
        overs = 0;
        @(negedge clk);
        mplier8 = 8'h19; mpcand8 = 8'hF9; sgn8 = 1'b1; go8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        go8 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_pdt", 64'(pdt8), 64'd0);
        chk("abort_busy", 64'(busy8), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            if (over8) overs++;
        end
        chk("abort_overs", 64'(overs), 64'd0);
        chk("abort_hold", 64'(pdt8), 64'd0);
        run_op("restart25xm7", 8'h19, 8'hF9, 1'b1, 16'hFF51, 4);

        // 16-bit signed operation with go held high so that it restarts back-to-back.
        first_lat = 0;
        second_lat = 0;
        @(negedge clk);
        mplier16 = 16'h8000; mpcand16 = 16'h7FFF; sgn16 = 1'b1; go16 = 1'b1;
        @(posedge clk); #1;
        for (int n = 1; n <= 24 && second_lat == 0; n++) begin
            @(posedge clk); #1;
            if (over16) begin
                if (first_lat == 0) begin
                    first_lat = n;
                    chk("w16_pdt1", 64'(pdt16), 64'hC0008000);
                end else begin
                    second_lat = n;
                    chk("w16_pdt2", 64'(pdt16), 64'hC0008000);
                end
            end
        end
        chk("w16_lat1", 64'(first_lat), 64'd8);
        chk("w16_period", 64'(second_lat - first_lat), 64'd10);
        @(negedge clk);
        go16 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
